// File: rtl/rr_pkg.sv
// Shared types and helpers for the round-robin grant controller.
// Requester IDs are 4 bits wide.
package rr_pkg;

    localparam int N_REQ = 16;
    localparam int ID_W  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic logic [ID_W-1:0] ptr_inc(
        input logic [ID_W-1:0] p
    );
        return p + 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority search over 16 requesters.
// Winner is the first set bit at or after pri, wrapping.
module rr_pick
    import rr_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  pri,
    output logic [ID_W-1:0]  winner,
    output logic             none
);

    logic [N_REQ-1:0] rot;
    logic [ID_W-1:0]  low;

    // Rotate so that bit pri lands at position 0.
    always_comb begin
        rot = (req >> pri) | (req << (ID_W'(N_REQ - 1) - pri + 1'b1));
        if (pri == '0) begin
            rot = req;
        end
    end

    // Lowest set bit of the rotated vector; scan high to low so the lowest wins.
    always_comb begin
        low = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                low = ID_W'(i);
            end
        end
    end

    // Undo the rotation; the 4-bit add wraps mod 16 naturally.
    always_comb begin
        winner = low + pri;
        none   = (req == '0);
    end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Sequential round-robin grant controller with held one-hot grants.
// A grant is released on done, on withdrawal, or after MAX_HOLD cycles.
module rr_grant_ctrl
    import rr_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic [ID_W-1:0]  pri,
    output logic             busy,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] HOLD_LAST =
        CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic HOLD_LIMITED = (MAX_HOLD != 0);

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;
    logic [ID_W-1:0]  winner;
    logic             none;
    logic             rel_done;
    logic             rel_wd;
    logic             rel_to;
    logic             release_now;

    rr_pick u_pick (
        .req    (req),
        .pri    (pri),
        .winner (winner),
        .none   (none)
    );

    // Release conditions for the grant currently held.
    always_comb begin
        rel_done    = done;
        rel_wd      = !req[grant_id];
        rel_to      = HOLD_LIMITED && (hold_cnt == HOLD_LAST);
        release_now = rel_done || rel_wd || rel_to;
    end

    // State machine, hold counter, pointer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            grant    <= '0;
            grant_id <= '0;
            pri      <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    if (!none) begin
                        state    <= HOLD;
                        grant    <= N_REQ'(1) << winner;
                        grant_id <= winner;
                        busy     <= 1'b1;
                        hold_cnt <= '0;
                    end
                end
                HOLD: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (release_now) begin
                        state   <= IDLE;
                        grant   <= '0;
                        busy    <= 1'b0;
                        pri     <= ptr_inc(grant_id);
                        timeout <= rel_to && !rel_done && !rel_wd;
                    end else begin
                        timeout <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Directed testbench for rr_grant_ctrl.
// Expected values are hand-computed for each step.
module tb_rr_grant_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic        done;
    logic [15:0] grant;
    logic [3:0]  grant_id;
    logic [3:0]  pri;
    logic        busy;
    logic        timeout;

    int tests  = 0;
    int failed = 0;

    rr_grant_ctrl #(
        .MAX_HOLD (8),
        .CNT_W    (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .done     (done),
        .grant    (grant),
        .grant_id (grant_id),
        .pri      (pri),
        .busy     (busy),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] g,
                           input logic [3:0] id, input logic [3:0] p,
                           input logic b, input logic t);
        chk({tag, ".grant"}, grant, g);
        chk({tag, ".id"}, {12'h0, grant_id}, {12'h0, id});
        chk({tag, ".pri"}, {12'h0, pri}, {12'h0, p});
        chk({tag, ".busy"}, {15'h0, busy}, {15'h0, b});
        chk({tag, ".timeout"}, {15'h0, timeout}, {15'h0, t});
    endtask

    initial begin
        rst  = 1'b1;
        req  = 16'h0;
        done = 1'b0;
        step();
        step();
        chk_all("reset", 16'h0, 4'd0, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_all("idle", 16'h0, 4'd0, 4'd0, 1'b0, 1'b0);
        end

        // Basic grant and release
        req = 16'h0021;
        step();
        chk_all("basic_g0", 16'h0001, 4'd0, 4'd0, 1'b1, 1'b0);
        done = 1'b1;
        step();
        chk_all("basic_rel", 16'h0, 4'd0, 4'd1, 1'b0, 1'b0);
        done = 1'b0;
        step();
        chk_all("basic_g5", 16'h0020, 4'd5, 4'd1, 1'b1, 1'b0);
        req = 16'h0;
        step();
        chk_all("basic_wd", 16'h0, 4'd5, 4'd6, 1'b0, 1'b0);

        // Wrap-around
        req = 16'h2000;
        step();
        chk_all("wrap_g13", 16'h2000, 4'd13, 4'd6, 1'b1, 1'b0);
        done = 1'b1;
        step();
        chk_all("wrap_rel13", 16'h0, 4'd13, 4'd14, 1'b0, 1'b0);
        done = 1'b0;
        req  = 16'h0003;
        step();
        chk_all("wrap_g0", 16'h0001, 4'd0, 4'd14, 1'b1, 1'b0);
        done = 1'b1;
        step();
        chk_all("wrap_rel0", 16'h0, 4'd0, 4'd1, 1'b0, 1'b0);
        done = 1'b0;
        step();
        chk_all("wrap_g1", 16'h0002, 4'd1, 4'd1, 1'b1, 1'b0);
        done = 1'b1;
        step();
        chk_all("wrap_rel1", 16'h0, 4'd1, 4'd2, 1'b0, 1'b0);
        done = 1'b0;
        req  = 16'h0;
        step();

        // Timeout after 8 cycles
        req = 16'h0100;
        step();
        chk_all("to_c1", 16'h0100, 4'd8, 4'd2, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step();
            chk_all("to_hold", 16'h0100, 4'd8, 4'd2, 1'b1, 1'b0);
        end
        step();
        chk_all("to_fire", 16'h0, 4'd8, 4'd9, 1'b0, 1'b1);
        step();
        chk_all("to_regrant", 16'h0100, 4'd8, 4'd9, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step();
        end
        chk_all("to_c8", 16'h0100, 4'd8, 4'd9, 1'b1, 1'b0);
        done = 1'b1;
        step();
        chk_all("to_done8", 16'h0, 4'd8, 4'd9, 1'b0, 1'b0);
        done = 1'b0;
        req  = 16'h0;
        step();
        chk_all("to_after", 16'h0, 4'd8, 4'd9, 1'b0, 1'b0);

        // Withdrawal, other req bits ignored while held
        req = 16'h0008;
        step();
        chk_all("wd_g3", 16'h0008, 4'd3, 4'd9, 1'b1, 1'b0);
        req = 16'h0018;
        step();
        chk_all("wd_other", 16'h0008, 4'd3, 4'd9, 1'b1, 1'b0);
        req = 16'h0010;
        step();
        chk_all("wd_rel", 16'h0, 4'd3, 4'd4, 1'b0, 1'b0);
        req  = 16'h0;
        done = 1'b1;
        step();
        chk_all("idle_done", 16'h0, 4'd3, 4'd4, 1'b0, 1'b0);
        done = 1'b0;
        step();
        chk_all("idle_done2", 16'h0, 4'd3, 4'd4, 1'b0, 1'b0);

        // Mid-grant reset then fair rotation
        req = 16'h4000;
        step();
        chk_all("mr_g14", 16'h4000, 4'd14, 4'd4, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        chk_all("mr_rst", 16'h0, 4'd0, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        req = 16'hFFFF;
        step();
        chk_all("rot_g0", 16'h0001, 4'd0, 4'd0, 1'b1, 1'b0);
        for (int k = 1; k < 5; k++) begin
            done = 1'b1;
            step();
            chk_all("rot_rel", 16'h0, 4'(k - 1), 4'(k), 1'b0, 1'b0);
            done = 1'b0;
            step();
            chk_all("rot_g", 16'h0001 << k, 4'(k), 4'(k), 1'b1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
